vga_plot_arbiter: RTL and testbench
===================================

VGA_PLOT_ARBITER -- requirements
Module: vga_plot_arbiter

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous active-high reset
- clear_req  in  1  start full-screen clear
- clear_colour  in  3  fill colour for the clear
- req0  in  1  snake pixel request (valid)
- x0 / y0 / c0  in  8 / 7 / 3  snake pixel coordinates and colour
- ack0  out  1  snake request accepted (ready)
- req1  in  1  tron pixel request (valid)
- x1 / y1 / c1  in  8 / 7 / 3  tron pixel coordinates and colour
- ack1  out  1  tron request accepted (ready)
- x  out  8  vga_adapter x
- y  out  7  vga_adapter y
- colour  out  3  vga_adapter colour
- plot  out  1  vga_adapter write enable
- clear_busy  out  1  clear sweep in progress
- clear_done  out  1  one-cycle pulse on the last clear pixel

Function
REQ-003 The FSM SHALL have two states, IDLE and CLEAR; x, y, colour, plot, clear_busy and clear_done are registered; ack0 and ack1 are combinational.
REQ-004 A transfer SHALL occur on a rising edge where reqN=1 and ackN=1; requesters hold reqN and their data stable until that edge.
REQ-005 In IDLE with clear_req=0, ackN SHALL be 1 for exactly one granted requester: the sole requester, or, if both request, the one not granted last (last_grant pointer).
REQ-006 ack0 and ack1 SHALL never both be 1, and SHALL both be 0 in CLEAR or when clear_req=1 in IDLE.
REQ-007 A transfer at edge n SHALL drive x, y, colour with the granted requester's data and plot=1 during the cycle after edge n (latency 1); last_grant updates at edge n.
REQ-008 Back-to-back transfers SHALL be supported: one accepted pixel per cycle, with plot held at 1 continuously.
REQ-009 A transfer with x>159 or y>119 SHALL be acknowledged but produce plot=0 (pixel dropped); the pointer still updates.
REQ-010 In any cycle with no transfer and no clear pixel, plot SHALL be 0; x, y and colour hold their last values.
REQ-011 clear_req=1 sampled in IDLE SHALL latch clear_colour, enter CLEAR, and set clear_busy=1; clear takes priority over any simultaneous request.
REQ-012 CLEAR SHALL plot one pixel per cycle, x fastest (0..159), then y (0..119), starting at (0,0) in the cycle after entry; 19200 plot cycles in total.
REQ-013 clear_done=1 SHALL coincide with the plot of (159,119); the next edge returns to IDLE with clear_busy=0; arbitration resumes in that IDLE cycle.
REQ-014 clear_req asserted while in CLEAR SHALL be ignored; a clear_req held high after completion SHALL start a new clear.
REQ-015 Requests during CLEAR SHALL be stalled without loss, never dropped.
REQ-016 Internal clear counters SHALL be 8-bit x and 7-bit y; x wraps 159->0 with y increment; no other wrap is used.

Reset
REQ-017 While reset=1 at an edge: state=IDLE, plot=0, x=0, y=0, colour=0, clear_busy=0, clear_done=0, last_grant=1 (so req0 wins the first tie), clear counters=0.
REQ-018 Reset during CLEAR SHALL abort the sweep with no clear_done pulse.
REQ-019 ack0/ack1 SHALL be 0 while reset=1.

Verification
REQ-020 Reset, then req0=1 (x0=10, y0=20, c0=3'b100) for one edge -> ack0=1 in that cycle; next cycle plot=1, x=10, y=20, colour=4; then plot=0.
REQ-021 req0=req1=1 held for 4 edges after reset -> grants in order 0,1,0,1; plot=1 for 4 consecutive cycles.
REQ-022 clear_req=1, clear_colour=3'b001, with req1=1 in the same cycle -> ack1=0; 19200 plot cycles from (0,0) to (159,119), colour=1; clear_done on the last cycle; ack1=1 in the first IDLE cycle after.
REQ-023 req0 with x0=160, y0=5 -> ack0=1, plot stays 0 the next cycle.
REQ-024 Start a clear, assert reset at pixel 500 -> all outputs 0 at the next cycle, no clear_done; a subsequent req0 is served normally.

Source files
------------

// File: rtl/vga_plot_arbiter.sv
// Two-requester pixel arbiter for the VGA adapter with a full-screen clear sweep.
// Round-robin grant between snake (0) and tron (1); clear pre-empts both.
module vga_plot_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_req,
  input  logic [2:0] clear_colour,
  input  logic       req0,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [2:0] c0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] x1,
  input  logic [6:0] y1,
  input  logic [2:0] c1,
  output logic       ack1,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       clear_busy,
  output logic       clear_done
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state, state_next;
  logic       last_grant;
  logic [7:0] cx;
  logic [6:0] cy;
  logic [2:0] clr_col;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The sweep stays in CLEAR for one extra cycle after the final pixel so that
  // clear_done and clear_busy=1 coincide with the (159,119) plot.
  always_comb begin
    state_next = state;
    ack0       = 1'b0;
    ack1       = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear_req) begin
          state_next = CLEAR;
        end else begin
          ack0 = req0 && (!req1 || last_grant);
          ack1 = req1 && (!req0 || !last_grant);
        end
      end
      CLEAR: begin
        if (clear_done) state_next = IDLE;
      end
    endcase
    if (reset) begin
      ack0 = 1'b0;
      ack1 = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
      last_grant <= 1'b1;
      cx         <= '0;
      cy         <= '0;
      clr_col    <= '0;
    end else begin
      plot       <= 1'b0;
      clear_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clear_req) begin
            // Pixel (0,0) is emitted on the entry edge; counters point at the next one.
            clr_col    <= clear_colour;
            colour     <= clear_colour;
            x          <= '0;
            y          <= '0;
            plot       <= 1'b1;
            clear_busy <= 1'b1;
            cx         <= 8'd1;
            cy         <= '0;
          end else if (ack0) begin
            x          <= x0;
            y          <= y0;
            colour     <= c0;
            plot       <= (x0 < 8'd160) && (y0 < 7'd120);
            last_grant <= 1'b0;
          end else if (ack1) begin
            x          <= x1;
            y          <= y1;
            colour     <= c1;
            plot       <= (x1 < 8'd160) && (y1 < 7'd120);
            last_grant <= 1'b1;
          end
        end
        CLEAR: begin
          if (clear_done) begin
            clear_busy <= 1'b0;
          end else begin
            x      <= cx;
            y      <= cy;
            colour <= clr_col;
            plot   <= 1'b1;
            if (cx == 8'd159) begin
              cx <= '0;
              if (cy == 7'd119) clear_done <= 1'b1;
              else              cy <= cy + 7'd1;
            end else begin
              cx <= cx + 8'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: directed scenarios plus randomized
// arbitration, compared against a pixel-index reference model.
module tb_vga_plot_arbiter;

  logic       clk;
  logic       reset;
  logic       clear_req;
  logic [2:0] clear_colour;
  logic       req0, req1;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic [2:0] c0, c1;
  logic       ack0, ack1;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, clear_busy, clear_done;

  vga_plot_arbiter dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .clear_colour(clear_colour),
    .req0(req0), .x0(x0), .y0(y0), .c0(c0), .ack0(ack0),
    .req1(req1), .x1(x1), .y1(y1), .c1(c1), .ack1(ack1),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .clear_busy(clear_busy), .clear_done(clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a clear is a walk over pixel index k = y*160 + x.
  bit         m_clr;
  int         m_k;
  bit         m_lg;
  logic [2:0] m_ccol;
  logic [7:0] mx;
  logic [6:0] my;
  logic [2:0] mcol;
  logic       mplot, mbusy, mdone;
  logic       acc0, acc1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic e0, e1;
    #1;
    e0 = !reset && !m_clr && !clear_req && req0 && (!req1 || m_lg);
    e1 = !reset && !m_clr && !clear_req && req1 && (!req0 || !m_lg);
    chk("ack0", 16'(ack0), 16'(e0));
    chk("ack1", 16'(ack1), 16'(e1));
    acc0 = e0;
    acc1 = e1;
    @(posedge clk);
    mdone = 1'b0;
    if (reset) begin
      m_clr = 0; m_k = 0; m_lg = 1; m_ccol = '0;
      mx = '0; my = '0; mcol = '0; mplot = 0; mbusy = 0;
    end else if (m_clr) begin
      if (m_k == 19200) begin
        m_clr = 0; mplot = 0; mbusy = 0;
      end else begin
        mx = 8'(m_k % 160); my = 7'(m_k / 160); mcol = m_ccol; mplot = 1;
        mdone = (m_k == 19199);
        m_k++;
      end
    end else if (clear_req) begin
      m_clr = 1; m_ccol = clear_colour; m_k = 1;
      mx = 0; my = 0; mcol = clear_colour; mplot = 1; mbusy = 1;
    end else if (e0) begin
      mx = x0; my = y0; mcol = c0; mplot = (int'(x0) < 160) && (int'(y0) < 120); m_lg = 0;
    end else if (e1) begin
      mx = x1; my = y1; mcol = c1; mplot = (int'(x1) < 160) && (int'(y1) < 120); m_lg = 1;
    end else begin
      mplot = 0;
    end
    @(negedge clk);
    chk("x", 16'(x), 16'(mx));
    chk("y", 16'(y), 16'(my));
    chk("colour", 16'(colour), 16'(mcol));
    chk("plot", 16'(plot), 16'(mplot));
    chk("clear_busy", 16'(clear_busy), 16'(mbusy));
    chk("clear_done", 16'(clear_done), 16'(mdone));
  endtask

  initial begin
    int np, nd;
    m_clr = 0; m_k = 0; m_lg = 1; m_ccol = '0;
    mx = '0; my = '0; mcol = '0; mplot = 0; mbusy = 0; mdone = 0;
    acc0 = 0; acc1 = 0;
    reset = 1; clear_req = 0; clear_colour = '0;
    req0 = 1; x0 = 8'd1; y0 = 7'd1; c0 = 3'd1;
    req1 = 1; x1 = 8'd2; y1 = 7'd2; c1 = 3'd2;
    @(negedge clk);
    tick();
    tick();
    chk("reset_plot", 16'(plot), 16'd0);

    // Single snake pixel
    reset = 0; req1 = 0;
    req0 = 1; x0 = 8'd10; y0 = 7'd20; c0 = 3'b100;
    tick();
    chk("single_plot", 16'(plot), 16'd1);
    chk("single_x", 16'(x), 16'd10);
    req0 = 0;
    tick();
    chk("single_idle_plot", 16'(plot), 16'd0);

    // Re-reset so the tie-break starts fresh, then hold both requests
    reset = 1; tick(); reset = 0;
    req0 = 1; x0 = 8'd30; y0 = 7'd31; c0 = 3'd5;
    req1 = 1; x1 = 8'd40; y1 = 7'd41; c1 = 3'd6;
    tick(); chk("rr_grant0_x", 16'(x), 16'd30);
    tick(); chk("rr_grant1_x", 16'(x), 16'd40);
    tick(); chk("rr_grant2_x", 16'(x), 16'd30);
    tick(); chk("rr_grant3_plot", 16'(plot), 16'd1);
    req0 = 0; req1 = 0;
    tick();

    // Out-of-range pixel is acknowledged but dropped
    req0 = 1; x0 = 8'd160; y0 = 7'd5; c0 = 3'd7;
    tick();
    chk("oor_plot", 16'(plot), 16'd0);
    req0 = 0;
    tick();

    // Randomized arbitration; requesters hold data until accepted
    for (int i = 0; i < 400; i++) begin
      if (!req0 || acc0) begin
        req0 = 1'($urandom_range(0, 1));
        x0 = 8'($urandom_range(0, 175)); y0 = 7'($urandom_range(0, 127)); c0 = 3'($urandom);
      end
      if (!req1 || acc1) begin
        req1 = 1'($urandom_range(0, 1));
        x1 = 8'($urandom_range(0, 175)); y1 = 7'($urandom_range(0, 127)); c1 = 3'($urandom);
      end
      tick();
    end

    // Full clear with a simultaneous tron request stalled behind it
    req0 = 0; req1 = 1; x1 = 8'd7; y1 = 7'd8; c1 = 3'd2;
    clear_req = 1; clear_colour = 3'b001;
    np = 0; nd = 0;
    tick();
    if (plot) np++;
    for (int i = 0; i < 19210 && m_clr; i++) begin
      if (i == 5) clear_req = 0;
      tick();
      if (plot) np++;
      if (clear_done) nd++;
    end
    chk("clear1_plot_count", 16'(np), 16'd19200);
    chk("clear1_done_count", 16'(nd), 16'd1);
    chk("clear1_busy_end", 16'(clear_busy), 16'd0);
    tick();
    chk("stalled_req1_x", 16'(x), 16'd7);
    req1 = 0;
    tick();

    // clear_req held across completion restarts the sweep, then reset aborts it
    clear_req = 1; clear_colour = 3'd6;
    tick();
    for (int i = 0; i < 19210 && m_clr; i++) tick();
    tick();
    chk("restart_busy", 16'(clear_busy), 16'd1);
    clear_req = 0;
    nd = 0;
    for (int i = 0; i < 600 && m_k < 500; i++) begin
      tick();
      if (clear_done) nd++;
    end
    reset = 1;
    tick();
    chk("abort_plot", 16'(plot), 16'd0);
    chk("abort_busy", 16'(clear_busy), 16'd0);
    chk("abort_done_count", 16'(nd), 16'd0);
    reset = 0;
    req0 = 1; x0 = 8'd50; y0 = 7'd60; c0 = 3'd5;
    tick();
    chk("post_abort_x", 16'(x), 16'd50);
    req0 = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
